multi_edge_detect: RTL and testbench

- Parametrised, multi-channel successor to the single-bit falling-edge detector, used by the calculator keypad/button front end.
- Each channel passes through a synchroniser and an optional debounce filter, then a per-channel selectable edge detector (rise/fall/both/off).
- Detected edges drive one-cycle pulses and sticky pending flags; software clears the flags per channel. The OR of all flags is an interrupt.

---
 rtl/multi_edge_detect.sv | 119 +++++++++++
 tb/tb_multi_edge_detect.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_edge_detect.sv
// Multi-channel edge detector: synchroniser, optional debounce, per-channel rise/fall/both/off
// select, one-cycle pulses, sticky pending flags and an OR'd irq. Debounce: MULTI_EDGE_DETECT_DEBOUNCE_EN.
module multi_edge_detect #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   in,
  input  logic [2*CH-1:0] mode,
  input  logic [CH-1:0]   clr,
  output logic [CH-1:0]   level,
  output logic [CH-1:0]   pulse,
  output logic [CH-1:0]   pend,
  output logic            irq
);

  if (CH < 1) begin : g_chCheck
    $error("multi_edge_detect: CH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_syncCheck
    $error("multi_edge_detect: SYNC_STAGES must be >= 2");
  end
  if (DB_CYCLES < 2) begin : g_dbCheck
    $error("multi_edge_detect: DB_CYCLES must be >= 2");
  end

  logic [CH-1:0] r_sync [SYNC_STAGES];
  logic [CH-1:0] r_level;
  logic [CH-1:0] r_pulse;
  logic [CH-1:0] r_pend;
  logic          r_irq;

  logic [CH-1:0] w_s;
  logic [CH-1:0] w_levelNext;
  logic [CH-1:0] w_pulseNext;
  logic [CH-1:0] w_pendNext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= '0;
      end
    end else begin
      r_sync[0] <= in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

`ifdef MULTI_EDGE_DETECT_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES);

  logic [CW-1:0] r_cnt     [CH];
  logic [CW-1:0] w_cntNext [CH];

  // A change is accepted only after DB_CYCLES consecutive differing samples; any agreement restarts the count.
  always_comb begin
    w_levelNext = r_level;
    for (int i = 0; i < CH; i++) begin
      w_cntNext[i] = '0;
      if (w_s[i] != r_level[i]) begin
        if (r_cnt[i] == CW'(DB_CYCLES - 1)) begin
          w_levelNext[i] = w_s[i];
        end else begin
          w_cntNext[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_cnt <= w_cntNext;
    end
  end
`else
  assign w_levelNext = w_s;
`endif

  // mode bit 2i enables rising edges, bit 2i+1 falling edges; mode is sampled at the edge itself.
  always_comb begin
    w_pulseNext = '0;
    for (int i = 0; i < CH; i++) begin
      w_pulseNext[i] = (w_levelNext[i] & ~r_level[i] & mode[2*i]) |
                       (~w_levelNext[i] & r_level[i] & mode[2*i+1]);
    end
  end

  assign w_pendNext = (r_pend & ~clr) | w_pulseNext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level <= '0;
      r_pulse <= '0;
      r_pend  <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_level <= w_levelNext;
      r_pulse <= w_pulseNext;
      r_pend  <= w_pendNext;
      r_irq   <= |w_pendNext;
    end
  end

  assign level = r_level;
  assign pulse = r_pulse;
  assign pend  = r_pend;
  assign irq   = r_irq;

endmodule

// File: tb/tb_multi_edge_detect.sv
// Scoreboard bench for multi_edge_detect: driver steps a behavioural model and queues the
// expected outputs for each clock; a negedge monitor pops and compares them.
module tb_multi_edge_detect;

  localparam int CH   = 4;
  localparam int SYNC = 2;
  localparam int DB   = 4;
`ifdef MULTI_EDGE_DETECT_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif
  localparam int LAT = DB_EN ? (SYNC + DB) : (SYNC + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   inSig;
  logic [2*CH-1:0] modeSig;
  logic [CH-1:0]   clrSig;
  logic [CH-1:0]   level;
  logic [CH-1:0]   pulse;
  logic [CH-1:0]   pend;
  logic            irq;

  typedef struct packed {
    logic [CH-1:0] level;
    logic [CH-1:0] pulse;
    logic [CH-1:0] pend;
    logic          irq;
  } exp_t;

  exp_t expQ[$];
  int checks = 0;
  int errors = 0;

  logic [CH-1:0]   curIn;
  logic [2*CH-1:0] curMode;
  logic [CH-1:0]   curClr;

  // Behavioural model state: delay line of sampled inputs, accepted levels, run lengths of disagreement.
  logic [CH-1:0] mLevel;
  logic [CH-1:0] mPulse;
  logic [CH-1:0] mPend;
  logic          mIrq;
  logic [CH-1:0] mDelay[$];
  int            mRun[CH];

  multi_edge_detect #(.CH(CH), .SYNC_STAGES(SYNC), .DB_CYCLES(DB)) dut (
    .clk   (clk),
    .rst   (rst),
    .in    (inSig),
    .mode  (modeSig),
    .clr   (clrSig),
    .level (level),
    .pulse (pulse),
    .pend  (pend),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  function automatic void modelReset();
    mLevel = '0;
    mPulse = '0;
    mPend  = '0;
    mIrq   = 1'b0;
    mDelay.delete();
    for (int k = 0; k < SYNC; k++) mDelay.push_back('0);
    for (int i = 0; i < CH; i++) mRun[i] = 0;
  endfunction

  function automatic void modelStep(input logic [CH-1:0] inV, input logic [2*CH-1:0] modeV,
                                    input logic [CH-1:0] clrV);
    logic [CH-1:0] s;
    logic [CH-1:0] newLevel;
    s = mDelay.pop_front();
    mDelay.push_back(inV);
    newLevel = mLevel;
    for (int i = 0; i < CH; i++) begin
      if (!DB_EN) begin
        newLevel[i] = s[i];
      end else if (s[i] == mLevel[i]) begin
        mRun[i] = 0;
      end else begin
        mRun[i] = mRun[i] + 1;
        if (mRun[i] == DB) begin
          newLevel[i] = s[i];
          mRun[i] = 0;
        end
      end
      mPulse[i] = (newLevel[i] != mLevel[i]) && (newLevel[i] ? modeV[2*i] : modeV[2*i+1]);
    end
    mPend  = (mPend & ~clrV) | mPulse;
    mIrq   = |mPend;
    mLevel = newLevel;
  endfunction

  function automatic void pushExpected();
    exp_t e;
    e.level = mLevel;
    e.pulse = mPulse;
    e.pend  = mPend;
    e.irq   = mIrq;
    expQ.push_back(e);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive inputs just after the falling edge, then advance the model on the rising edge.
  task automatic applyStimulus(input logic [CH-1:0] inV, input logic [2*CH-1:0] modeV,
                               input logic [CH-1:0] clrV, input logic rstV);
    @(negedge clk);
    #2;
    inSig   = inV;
    modeSig = modeV;
    clrSig  = clrV;
    rst     = rstV;
    @(posedge clk);
    if (rstV) modelStep(inV, modeV, clrV);
    else      modelReset();
    pushExpected();
  endtask

  task automatic runCycles(input int n, input int ch, output int cnt);
    cnt = 0;
    repeat (n) begin
      applyStimulus(curIn, curMode, curClr, 1'b1);
      #1;
      if (pulse[ch]) cnt++;
    end
  endtask

  task automatic measureLatency(input int ch);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    curIn[ch] = 1'b1;
    while (!seen && n < 60) begin
      applyStimulus(curIn, curMode, curClr, 1'b1);
      n++;
      #1;
      seen = pulse[ch];
    end
    checkOutput("latency", seen ? n : 999, LAT);
  endtask

  task automatic midReset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("asyncLevel", level, 0);
    checkOutput("asyncPulse", pulse, 0);
    checkOutput("asyncPend",  pend,  0);
    checkOutput("asyncIrq",   irq,   0);
    @(posedge clk);
    modelReset();
    pushExpected();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("level", level, e.level);
      checkOutput("pulse", pulse, e.pulse);
      checkOutput("pend",  pend,  e.pend);
      checkOutput("irq",   irq,   e.irq);
    end
  end

  initial begin
    int cnt;
    int cntA;
    int cntB;
    int waitCycles;
    bit seen;
    logic [CH-1:0] snap;
    logic [1:0] modes [3];

    rst = 1'b1;
    inSig = '0;
    modeSig = '1;
    clrSig = '0;
    curIn = '0;
    curMode = '1;
    curClr = '0;
    modelReset();
    #1;
    rst = 1'b0;
    #1;
    checkOutput("resetLevel", level, 0);
    checkOutput("resetPulse", pulse, 0);
    checkOutput("resetPend",  pend,  0);
    checkOutput("resetIrq",   irq,   0);
    repeat (3) applyStimulus(curIn, curMode, curClr, 1'b0);
    runCycles(5, 0, cnt);

    measureLatency(0);
    runCycles(10, 0, cnt);
    checkOutput("pend0Set", pend[0], 1);
    checkOutput("irqSet", irq, 1);
    curClr = '1;
    runCycles(1, 0, cnt);
    curClr = '0;
    curIn[0] = 1'b0;
    runCycles(20, 0, cnt);
    checkOutput("fallPulses0", cnt, 1);
    curClr = '1;
    runCycles(1, 0, cnt);
    curClr = '0;

    modes[0] = 2'b01;
    modes[1] = 2'b10;
    modes[2] = 2'b00;
    for (int m = 0; m < 3; m++) begin
      curMode[3:2] = modes[m];
      curIn[1] = 1'b1;
      runCycles(20, 1, cntA);
      checkOutput("levelFollowHi", level[1], 1);
      curIn[1] = 1'b0;
      runCycles(20, 1, cntB);
      checkOutput("levelFollowLo", level[1], 0);
      checkOutput("risePulses", cntA, modes[m][0]);
      checkOutput("fallPulses", cntB, modes[m][1]);
    end
    curMode = '1;
    curClr = '1;
    runCycles(1, 0, cnt);

    curClr = 4'b0100;
    curIn[2] = 1'b1;
    runCycles(20, 2, cnt);
    checkOutput("racePulses", cnt, 1);
    curClr = '0;
    runCycles(2, 2, cnt);
    checkOutput("racePendLow", pend[2], 0);
    curClr = 4'b0100;
    runCycles(1, 2, cnt);
    curClr = '0;
    runCycles(1, 2, cnt);
    checkOutput("idleClr", pend[2], 0);
    curIn[2] = 1'b0;
    runCycles(20, 2, cnt);
    curClr = '1;
    runCycles(1, 0, cnt);
    curClr = '0;

    curIn[3] = 1'b1;
    runCycles(DB - 1, 3, cntA);
    curIn[3] = 1'b0;
    runCycles(20, 3, cntB);
    checkOutput("glitchPulses", cntA + cntB, DB_EN ? 0 : 2);
    measureLatency(3);
    curIn[3] = 1'b0;
    runCycles(20, 3, cnt);
    curClr = '1;
    runCycles(1, 0, cnt);
    curClr = '0;

    curIn = ~curIn;
    seen = 1'b0;
    snap = '0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(curIn, curMode, curClr, 1'b1);
      #1;
      if (!seen && pulse != '0) begin
        seen = 1'b1;
        snap = pulse;
      end
    end
    checkOutput("allPulse", snap, 4'b1111);
    checkOutput("allPend", pend, 4'b1111);
    curClr = 4'b0101;
    runCycles(1, 0, cnt);
    curClr = '0;
    checkOutput("partClrPend", pend, 4'b1010);
    checkOutput("partClrIrq", irq, 1);

    curIn[0] = 1'b0;
    runCycles(DB_EN ? SYNC + 2 : SYNC, 0, cnt);
    midReset();
    curIn = '0;
    repeat (3) applyStimulus(curIn, curMode, curClr, 1'b0);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(curIn, curMode, curClr, 1'b1);
      #1;
      if (pulse != '0) cnt++;
    end
    checkOutput("postResetPulses", cnt, 0);

    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 7) == 0) curIn[i] = ~curIn[i];
      end
      if ($urandom_range(0, 15) == 0) curMode = 8'($urandom);
      curClr = 4'($urandom & $urandom & $urandom);
      applyStimulus(curIn, curMode, curClr, 1'b1);
    end

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    checkOutput("drain", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
